// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : Pipeline memory-access stage: req/ack data-memory port with
//            stall, access timeout, and the M/WB pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_alu_result,
    input  logic [15:0] in_op1_val,
    input  logic [15:0] in_r15_result,
    input  logic [3:0]  in_dest_reg,
    input  logic        in_wb,
    input  logic        in_r15_we,
    input  logic        in_mem_rd,
    input  logic        in_mem_wr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        out_valid,
    output logic        out_wb,
    output logic [15:0] out_data,
    output logic [3:0]  out_dest_reg,
    output logic        out_r15_we,
    output logic [15:0] out_r15_result,
    output logic        err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_countLast = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_countOne  = CNT_W'(1);

    state_t           r_state;
    state_t           w_stateNext;
    logic [CNT_W-1:0] r_count;
    logic             w_memOp;
    logic             w_isWait;
    logic             w_ackHit;
    logic             w_timeoutHit;

    assign w_memOp      = in_valid & (in_mem_rd | in_mem_wr);
    assign w_isWait     = (r_state == S_WAIT);
    assign w_ackHit     = w_isWait & mem_ack;
    assign w_timeoutHit = w_isWait & ~mem_ack & (r_count == c_countLast);

    // Gated by rst so upstream sees no stall while the stage is held in reset.
    assign stall = rst & ((~w_isWait & w_memOp) | (w_isWait & ~mem_ack & ~w_timeoutHit));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: if (w_memOp) w_stateNext = S_WAIT;
            S_WAIT: if (w_ackHit || w_timeoutHit) w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
    end

    // Memory port and timeout counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            r_count   <= '0;
            err       <= 1'b0;
        end else if (!w_isWait) begin
            if (w_memOp) begin
                mem_req   <= 1'b1;
                mem_we    <= in_mem_wr;
                mem_addr  <= in_alu_result;
                mem_wdata <= in_op1_val;
                r_count   <= '0;
            end
        end else if (w_ackHit) begin
            mem_req <= 1'b0;
        end else if (w_timeoutHit) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
        end else begin
            r_count <= r_count + c_countOne;
        end
    end

    // M/WB register; data fields load every edge, enables decide liveness.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid      <= 1'b0;
            out_wb         <= 1'b0;
            out_r15_we     <= 1'b0;
            out_data       <= 16'h0000;
            out_dest_reg   <= 4'h0;
            out_r15_result <= 16'h0000;
        end else begin
            out_dest_reg   <= in_dest_reg;
            out_r15_result <= in_r15_result;
            out_data       <= (w_ackHit && !mem_we) ? mem_rdata : in_alu_result;
            if (w_ackHit) begin
                out_valid  <= 1'b1;
                out_wb     <= in_wb & ~mem_we;
                out_r15_we <= in_r15_we;
            end else if (w_isWait || w_memOp) begin
                out_valid  <= 1'b0;
                out_wb     <= 1'b0;
                out_r15_we <= 1'b0;
            end else begin
                out_valid  <= in_valid;
                out_wb     <= in_wb;
                out_r15_we <= in_r15_we;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Self-checking bench for mem_access_stage (directed + random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_alu_result;
    logic [15:0] in_op1_val;
    logic [15:0] in_r15_result;
    logic [3:0]  in_dest_reg;
    logic        in_wb;
    logic        in_r15_we;
    logic        in_mem_rd;
    logic        in_mem_wr;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        out_valid;
    logic        out_wb;
    logic [15:0] out_data;
    logic [3:0]  out_dest_reg;
    logic        out_r15_we;
    logic [15:0] out_r15_result;
    logic        err;

    int   errors = 0;
    int   checks = 0;
    logic errExp = 1'b0;

    mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_alu_result(in_alu_result), .in_op1_val(in_op1_val),
        .in_r15_result(in_r15_result), .in_dest_reg(in_dest_reg), .in_wb(in_wb),
        .in_r15_we(in_r15_we), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
        .out_valid(out_valid), .out_wb(out_wb), .out_data(out_data),
        .out_dest_reg(out_dest_reg), .out_r15_we(out_r15_we),
        .out_r15_result(out_r15_result), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction and follows it to completion. ackAfter is the
    // WAIT cycle index that receives mem_ack; -1 means never acknowledged.
    task automatic doInstr(input logic v, input logic [15:0] alu, input logic [15:0] op1,
                           input logic [15:0] r15, input logic [3:0] dest, input logic wb,
                           input logic r15we, input logic rd, input logic wr, input int ackAfter);
        logic        isMem;
        logic [15:0] rdata;
        isMem         = v & (rd | wr);
        in_valid      = v;
        in_alu_result = alu;
        in_op1_val    = op1;
        in_r15_result = r15;
        in_dest_reg   = dest;
        in_wb         = wb;
        in_r15_we     = r15we;
        in_mem_rd     = rd;
        in_mem_wr     = wr;
        mem_ack       = 1'b0;
        if (!isMem) begin
            mem_ack   = 1'($urandom % 2);
            mem_rdata = 16'($urandom);
            #1 chk("stall_nonmem", stall, 1'b0);
            tick();
            mem_ack = 1'b0;
            chk("req_nonmem", mem_req, 1'b0);
            chk("valid_nonmem", out_valid, v);
            chk("wb_nonmem", out_wb, wb);
            chk("r15we_nonmem", out_r15_we, r15we);
            if (v) begin
                chk("data_nonmem", out_data, alu);
                chk("dest_nonmem", out_dest_reg, dest);
                chk("r15_nonmem", out_r15_result, r15);
            end
        end else begin
            #1 chk("stall_issue", stall, 1'b1);
            tick();
            chk("req_issue", mem_req, 1'b1);
            chk("we_issue", mem_we, wr);
            chk("addr_issue", mem_addr, alu);
            chk("wdata_issue", mem_wdata, op1);
            chk("valid_issue", out_valid, 1'b0);
            for (int k = 0; k < TIMEOUT; k++) begin
                if (k == ackAfter) begin
                    rdata     = 16'($urandom);
                    mem_rdata = rdata;
                    mem_ack   = 1'b1;
                    #1 chk("stall_ack", stall, 1'b0);
                    tick();
                    mem_ack = 1'b0;
                    chk("req_done", mem_req, 1'b0);
                    chk("valid_done", out_valid, 1'b1);
                    chk("data_done", out_data, wr ? alu : rdata);
                    chk("wb_done", out_wb, wb & ~wr);
                    chk("r15we_done", out_r15_we, r15we);
                    chk("dest_done", out_dest_reg, dest);
                    chk("r15_done", out_r15_result, r15);
                    break;
                end else if (k == TIMEOUT - 1) begin
                    #1 chk("stall_timeout", stall, 1'b0);
                    tick();
                    errExp = 1'b1;
                    chk("req_timeout", mem_req, 1'b0);
                    chk("valid_timeout", out_valid, 1'b0);
                end else begin
                    #1 chk("stall_wait", stall, 1'b1);
                    tick();
                    chk("req_wait", mem_req, 1'b1);
                    chk("we_wait", mem_we, wr);
                    chk("addr_wait", mem_addr, alu);
                    chk("wdata_wait", mem_wdata, op1);
                    chk("valid_wait", out_valid, 1'b0);
                end
            end
        end
        chk("err", err, errExp);
    endtask

    initial begin
        rst           = 1'b0;
        in_valid      = 1'b1;
        in_alu_result = 16'h5555;
        in_op1_val    = 16'h0000;
        in_r15_result = 16'h0000;
        in_dest_reg   = 4'h0;
        in_wb         = 1'b0;
        in_r15_we     = 1'b0;
        in_mem_rd     = 1'b1;
        in_mem_wr     = 1'b0;
        mem_rdata     = 16'h0000;
        mem_ack       = 1'b0;
        #2;
        chk("rst_stall", stall, 1'b0);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 16'h0000);
        chk("rst_err", err, 1'b0);
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;

        // ALU op, load with immediate ack, store with 3-cycle stall
        doInstr(1'b1, 16'h1234, 16'h0000, 16'h0000, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        doInstr(1'b1, 16'h0040, 16'h0000, 16'h0000, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        doInstr(1'b1, 16'h0010, 16'h00AA, 16'h0000, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 2);

        // Timeout, then a normal ALU op with err held
        doInstr(1'b1, 16'h0080, 16'h0000, 16'h0000, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, -1);
        doInstr(1'b1, 16'h4321, 16'h0000, 16'h00F0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, -1);

        // Back-to-back load, ALU, store; then a rd+wr access (acts as store)
        doInstr(1'b1, 16'h0100, 16'h0000, 16'h0000, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        doInstr(1'b1, 16'h0BAD, 16'h0000, 16'h0000, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        doInstr(1'b1, 16'h0200, 16'h1111, 16'h0000, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        doInstr(1'b1, 16'h0300, 16'h2222, 16'h0000, 4'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1);

        // Reset while an access is outstanding
        in_valid      = 1'b1;
        in_alu_result = 16'h0900;
        in_mem_rd     = 1'b1;
        in_mem_wr     = 1'b0;
        in_wb         = 1'b1;
        tick();
        tick();
        chk("midwait_req", mem_req, 1'b1);
        rst = 1'b0;
        #1;
        errExp = 1'b0;
        chk("midrst_req", mem_req, 1'b0);
        chk("midrst_stall", stall, 1'b0);
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_err", err, 1'b0);
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        doInstr(1'b1, 16'h0044, 16'h0000, 16'h0000, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 0);

        // Random instruction stream
        for (int n = 0; n < 150; n++) begin
            logic v, rd, wr, wb, r15we;
            int   kind, ackAfter;
            v        = ($urandom % 8) != 0;
            kind     = int'($urandom % 4);
            rd       = (kind == 1) || (kind == 3);
            wr       = (kind == 2) || (kind == 3);
            wb       = v & 1'($urandom % 2);
            r15we    = v & 1'($urandom % 2);
            ackAfter = (($urandom % 12) == 0) ? -1 : int'($urandom % 5);
            doInstr(v, 16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom),
                    wb, r15we, rd, wr, ackAfter);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage of the 16-bit pipeline. Sits directly downstream of the EX/M pipeline register and consumes its outputs: ALU result as address, operand-1 value as store data, R15 result, destination register, write-back flag.
- Performs loads and stores over a req/ack data-memory port and stalls the pipeline while an access is outstanding.
- Registers the result into the M/WB pipeline register that feeds write-back.
- A timeout counter aborts accesses that are never acknowledged.

Parameters:
- TIMEOUT, 15, number of WAIT cycles without mem_ack before abort (1..255).
- CNT_W, 8, width of the timeout counter.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-low
- in_valid  input  1  EX/M holds a live instruction
- in_alu_result  input  16  ALU result; memory address for loads/stores
- in_op1_val  input  16  store data
- in_r15_result  input  16  R15 side result
- in_dest_reg  input  4  destination register number
- in_wb  input  1  instruction writes back a register
- in_r15_we  input  1  instruction writes R15
- in_mem_rd  input  1  load
- in_mem_wr  input  1  store
- mem_req  output  1  access request, registered
- mem_we  output  1  1 = store, 0 = load
- mem_addr  output  16  access address, registered
- mem_wdata  output  16  store data, registered
- mem_rdata  input  16  load data, valid when mem_ack=1
- mem_ack  input  1  one-cycle access-complete pulse
- stall  output  1  hold EX/M and all upstream stages, combinational
- out_valid  output  1  M/WB holds a live instruction
- out_wb  output  1  register write enable to write-back
- out_data  output  16  write-back data: load data or ALU result
- out_dest_reg  output  4  write-back register number
- out_r15_we  output  1  R15 write enable
- out_r15_result  output  16  R15 write data
- err  output  1  sticky access-timeout flag

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, every output register 0 (mem_req, mem_we, mem_addr, mem_wdata, all out_*, err). stall evaluates to 0.
- mem_op = in_valid & (in_mem_rd | in_mem_wr). If both rd and wr are set, the access is a store and there is no register write-back.
- States:
  - IDLE: if mem_op, latch mem_addr=in_alu_result, mem_wdata=in_op1_val, mem_we=in_mem_wr; set mem_req=1 and counter=0; go to WAIT.
  - WAIT: mem_req stays 1 and addr/wdata/we are held stable. Counter increments each cycle with no ack.
    - mem_ack=1: mem_req<=0, go to IDLE.
    - No ack and counter==TIMEOUT-1: mem_req<=0, err<=1, go to IDLE. The instruction is dropped.
- mem_ack is ignored in IDLE.
- stall = (IDLE & mem_op) | (WAIT & !mem_ack & !timeout_hit). On the ack or timeout cycle stall drops, so EX/M advances on that same edge. The access is never re-issued.
- M/WB register, updated every edge:
  - Non-memory instruction in IDLE: out_valid<=in_valid; out_data<=in_alu_result; out_wb<=in_wb; out_r15_we<=in_r15_we; out_dest_reg and out_r15_result are copied.
  - Any stalled cycle: out_valid, out_wb, out_r15_we <=0 (bubble). Data fields are don't-care.
  - Ack cycle: out_valid<=1; out_data<=mem_rdata for a load, in_alu_result for a store; out_wb<=in_wb & !mem_we; R15 fields taken from inputs.
  - Timeout cycle: bubble (all enables 0).
- Latency: a non-memory instruction appears in M/WB 1 edge after it is presented. A load with ack on the first WAIT cycle takes 2 edges, with 1 stall cycle beyond that.
- err clears only on reset.
- Reset in WAIT aborts the access immediately: mem_req=0, no write-back.

Test Plan:
- ALU op: in_valid=1, alu=0x1234, dest=3, wb=1 -> next edge out_valid=1, out_data=0x1234, out_dest_reg=3, stall never asserted.
- Load with ack: rd=1, alu=0x0040, dest=5; ack with rdata=0xBEEF on the first WAIT cycle -> stall=1 for 1 cycle, mem_req=1/mem_we=0/addr=0x0040 for 1 cycle, then out_data=0xBEEF, out_wb=1, out_dest_reg=5.
- Store with 3-cycle ack delay: wr=1, alu=0x0010, op1=0x00AA -> mem_we=1, wdata=0x00AA held stable 3 cycles, stall high 3 cycles, out_valid=1 with out_wb=0.
- Timeout: rd=1, no ack -> after 15 WAIT cycles mem_req=0, err=1, stall drops, out_valid=0. A following ALU op completes normally and err stays 1.
- Back-to-back: load, then ALU op, then store with immediate acks -> three M/WB results in program order, no duplicate mem_req, and bubbles only during stalls.
- Reset mid-WAIT: drop rst while mem_req=1 -> mem_req, stall, out_valid and err all 0 at once. A later load proceeds normally.
